// File: rtl/cpu_sequencer.sv
// cpu_sequencer: CPU cycle FSM driving the decoder state, with run/step debug control,
// a retired-instruction counter and halt/multiplier-fault status.
module cpu_sequencer #(
  parameter int COUNT_W     = 16,
  parameter int MUL_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step_mode,
  input  logic               step,
  input  logic               restart,
  input  logic               sm_extra,
  input  logic               stop,
  input  logic               mul_req,
  input  logic               mul_done,
  output logic [1:0]         state,
  output logic               busy,
  output logic               halted,
  output logic               mul_fault,
  output logic [COUNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC1, EXEC2, MUL_WAIT, HALT} fsm_t;
  fsm_t fsm, nxt, after;
  logic step_q, step_rise, free, retire, fault_set;
  logic [7:0] tmr, tmr_nxt;
  assign step_rise = step & ~step_q;
  assign free      = run & ~step_mode;
  // retirement chains straight into the next fetch, so back-to-back instructions have no gap
  assign after     = free ? FETCH : IDLE;
  always_comb begin
    nxt       = fsm;
    tmr_nxt   = tmr;
    retire    = 1'b0;
    fault_set = 1'b0;
    case (fsm)
      IDLE:  nxt = (free | (step_mode & step_rise)) ? FETCH : IDLE;
      FETCH: nxt = stop ? HALT : EXEC1;
      EXEC1: begin
        if (stop) nxt = HALT;
        else if (mul_req) begin
          nxt     = MUL_WAIT;
          tmr_nxt = '0;
        end else if (sm_extra) nxt = EXEC2;
        else begin
          retire = 1'b1;
          nxt    = after;
        end
      end
      EXEC2: begin
        nxt    = stop ? HALT : after;
        retire = ~stop;
      end
      MUL_WAIT: begin
        if (stop) nxt = HALT;
        else if (mul_done) begin
          retire = 1'b1;
          nxt    = after;
        end else if (tmr == 8'(MUL_TIMEOUT - 1)) begin
          nxt       = HALT;
          fault_set = 1'b1;
        end else tmr_nxt = tmr + 8'd1;
      end
      HALT:    nxt = restart ? IDLE : HALT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      step_q      <= 1'b0;
      tmr         <= '0;
      state       <= 2'b11;
      busy        <= 1'b0;
      halted      <= 1'b0;
      mul_fault   <= 1'b0;
      instr_count <= '0;
    end else begin
      fsm         <= nxt;
      step_q      <= step;
      tmr         <= tmr_nxt;
      state       <= (nxt == FETCH) ? 2'b00 : (nxt == EXEC1) ? 2'b10 : (nxt == EXEC2) ? 2'b01 : 2'b11;
      busy        <= (nxt == FETCH) | (nxt == EXEC1) | (nxt == EXEC2) | (nxt == MUL_WAIT);
      halted      <= nxt == HALT;
      mul_fault   <= fault_set ? 1'b1 : (fsm == HALT && restart) ? 1'b0 : mul_fault;
      instr_count <= retire ? instr_count + 1'b1 : instr_count;
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scoreboard bench; stimulus queues expected outputs, a negedge monitor checks them.
module tb_cpu_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic run = 0, step_mode = 0, step = 0, restart = 0, sm_extra = 0, stop = 0, mul_req = 0, mul_done = 0;
  logic [1:0] state;
  logic busy, halted, mul_fault;
  logic [15:0] instr_count;
  int total = 0, bad = 0;
  logic [20:0] q[$];

  localparam logic [7:0] R = 8'h80, SM = 8'h40, ST = 8'h20, RS = 8'h10, EX = 8'h08, SP = 8'h04, MQ = 8'h02, MD = 8'h01;
  localparam logic [1:0] F = 2'b00, E1 = 2'b10, E2 = 2'b01, I = 2'b11;

  cpu_sequencer #(.COUNT_W(16), .MUL_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode), .step(step), .restart(restart),
    .sm_extra(sm_extra), .stop(stop), .mul_req(mul_req), .mul_done(mul_done),
    .state(state), .busy(busy), .halted(halted), .mul_fault(mul_fault), .instr_count(instr_count));

  always #5 clk = ~clk;

  function automatic logic [20:0] snap();
    return {state, busy, halted, mul_fault, instr_count};
  endfunction

  task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got st=%b busy=%b halt=%b fault=%b cnt=%0d, want st=%b busy=%b halt=%b fault=%b cnt=%0d",
               name, got[20:19], got[18], got[17], got[16], got[15:0], exp[20:19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) chk("cycle", snap(), q.pop_front());

  task automatic cy(input logic [7:0] i, input logic [1:0] s, input logic b, input logic h, input logic f, input logic [15:0] c);
    {run, step_mode, step, restart, sm_extra, stop, mul_req, mul_done} = i;
    @(posedge clk);
    #1 q.push_back({s, b, h, f, c});
  endtask

  initial begin
    @(posedge clk); #1 q.push_back({I, 3'b000, 16'd0});
    @(posedge clk); #1 q.push_back({I, 3'b000, 16'd0});
    rst_n = 1'b1;
    // free run, 2-cycle instructions
    cy(R, F, 1, 0, 0, 0);  cy(R, E1, 1, 0, 0, 0);
    cy(R, F, 1, 0, 0, 1);  cy(R, E1, 1, 0, 0, 1);
    cy(R, F, 1, 0, 0, 2);
    // EXEC2 instruction
    cy(R, E1, 1, 0, 0, 2); cy(R | EX, E2, 1, 0, 0, 2); cy(R, F, 1, 0, 0, 3);
    // multiplier answering in the third wait cycle
    cy(R, E1, 1, 0, 0, 3); cy(R | MQ, I, 1, 0, 0, 3);
    cy(R, I, 1, 0, 0, 3);  cy(R, I, 1, 0, 0, 3);
    cy(R | MD, F, 1, 0, 0, 4);
    // multiplier timeout
    cy(R, E1, 1, 0, 0, 4); cy(R | MQ, I, 1, 0, 0, 4);
    for (int k = 0; k < 14; k++) cy(R, I, 1, 0, 0, 4);
    cy(R, I, 0, 1, 1, 4);
    cy(R | MD, I, 0, 1, 1, 4);
    cy(RS, I, 0, 0, 0, 4);
    // single-step with step held high, then a second edge
    cy(SM, I, 0, 0, 0, 4);
    cy(SM | ST, F, 1, 0, 0, 4); cy(SM | ST, E1, 1, 0, 0, 4); cy(SM | ST, I, 0, 0, 0, 5);
    for (int k = 0; k < 7; k++) cy(SM | ST, I, 0, 0, 0, 5);
    cy(SM, I, 0, 0, 0, 5);
    cy(SM | ST, F, 1, 0, 0, 5); cy(SM, E1, 1, 0, 0, 5); cy(SM, I, 0, 0, 0, 6);
    cy(RS | SM, I, 0, 0, 0, 6);
    // stop beats mul_req and sm_extra in EXEC1
    cy(R, F, 1, 0, 0, 6); cy(R, E1, 1, 0, 0, 6);
    cy(R | SP | MQ | EX, I, 0, 1, 0, 6);
    cy(R, I, 0, 1, 0, 6);
    cy(R | RS, I, 0, 0, 0, 6);
    // asynchronous reset in the middle of EXEC2
    cy(R, F, 1, 0, 0, 6); cy(R, E1, 1, 0, 0, 6); cy(R | EX, E2, 1, 0, 0, 6);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 chk("async_reset", snap(), {I, 3'b000, 16'd0});
    @(posedge clk); #1 q.push_back({I, 3'b000, 16'd0});
    rst_n = 1'b1;
    // stop in FETCH
    cy(R, F, 1, 0, 0, 0);
    cy(R | SP, I, 0, 1, 0, 0);
    cy(0, I, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
